// File: rtl/ps2_key_tracker_if.sv
// Byte-in / event-out bus of the PS/2 key tracker.
// master drives received bytes and the event ready; slave is the tracker itself.
interface ps2_key_tracker_if;
  logic [7:0] rxData;
  logic       rxValid;
  logic       evValid;
  logic       evReady;
  logic [4:0] evKey;
  logic       evPressed;

  modport master (output rxData, rxValid, evReady, input evValid, evKey, evPressed);
  modport slave  (input rxData, rxValid, evReady, output evValid, evKey, evPressed);
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code set 2 decoder: per-key held state plus a press/release event FIFO.
// Handles break and E0 prefixes, an inter-byte timeout and keyboard self-test bytes.
module ps2_key_tracker #(
  parameter int unsigned NUM_KEYS       = 29,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter bit          EXT_AS_BASE    = 1'b0,
  parameter bit          REPEAT_EVENTS  = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  ps2_key_tracker_if.slave    bus,
  output logic [NUM_KEYS-1:0] keyState,
  output logic                evOverflow,
  input  logic                clearOverflow,
  output logic                syncError
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] KEY_ONE   = NUM_KEYS'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BREAK   = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  // Returns {hit, index} for the fixed code-to-key table.
  function automatic logic [5:0] mapCode(input logic [7:0] code);
    case (code)
      8'h45: mapCode = {1'b1, 5'd0};   8'h16: mapCode = {1'b1, 5'd1};
      8'h1E: mapCode = {1'b1, 5'd2};   8'h26: mapCode = {1'b1, 5'd3};
      8'h25: mapCode = {1'b1, 5'd4};   8'h2E: mapCode = {1'b1, 5'd5};
      8'h36: mapCode = {1'b1, 5'd6};   8'h3D: mapCode = {1'b1, 5'd7};
      8'h3E: mapCode = {1'b1, 5'd8};   8'h46: mapCode = {1'b1, 5'd9};
      8'h0E: mapCode = {1'b1, 5'd10};  8'h4E: mapCode = {1'b1, 5'd11};
      8'h55: mapCode = {1'b1, 5'd12};  8'h66: mapCode = {1'b1, 5'd13};
      8'h0D: mapCode = {1'b1, 5'd14};  8'h15: mapCode = {1'b1, 5'd15};
      8'h1D: mapCode = {1'b1, 5'd16};  8'h24: mapCode = {1'b1, 5'd17};
      8'h2D: mapCode = {1'b1, 5'd18};  8'h2C: mapCode = {1'b1, 5'd19};
      8'h35: mapCode = {1'b1, 5'd20};  8'h3C: mapCode = {1'b1, 5'd21};
      8'h43: mapCode = {1'b1, 5'd22};  8'h44: mapCode = {1'b1, 5'd23};
      8'h4D: mapCode = {1'b1, 5'd24};  8'h54: mapCode = {1'b1, 5'd25};
      8'h5B: mapCode = {1'b1, 5'd26};  8'h5D: mapCode = {1'b1, 5'd27};
      8'h29: mapCode = {1'b1, 5'd28};  8'h5A: mapCode = {1'b1, 5'd29};
      8'h76: mapCode = {1'b1, 5'd30};  8'h12: mapCode = {1'b1, 5'd31};
      default: mapCode = 6'd0;
    endcase
  endfunction

  logic [7:0]          rxData;
  logic                rxValid;
  logic [1:0]          state, stateNext;
  logic [TO_W-1:0]     toCnt, toCntNext;
  logic                doMake, doBreak, doClear, errNext;
  logic [5:0]          mapped;
  logic [4:0]          keyIdx;
  logic                keyHit, keyHeld;
  logic [NUM_KEYS-1:0] keyOneHot, keyNext;
  logic                pushReq, pushPressed;
  logic [5:0]          fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rdPtr, wrPtr, rdNext;
  logic [CNT_W-1:0]    count, countNext;
  logic                full, pop, pushOk, drop, validNext;
  logic [5:0]          pushEntry, headNext;

  assign rxData  = bus.rxData;
  assign rxValid = bus.rxValid;

  // Sequence FSM and inter-byte timeout.
  always_comb begin
    stateNext = state;
    toCntNext = toCnt;
    errNext   = 1'b0;
    doMake    = 1'b0;
    doBreak   = 1'b0;
    doClear   = 1'b0;
    if (rxValid) begin
      toCntNext = '0;
      case (state)
        ST_IDLE: begin
          if (rxData == CODE_BRK)                        stateNext = ST_BREAK;
          else if (rxData == CODE_EXT)                   stateNext = ST_EXT;
          else if (rxData inside {8'hAA, 8'hFC})         doClear   = 1'b1;
          else if (!(rxData inside {8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) doMake = 1'b1;
        end
        ST_BREAK: begin
          stateNext = ST_IDLE;
          if (rxData == CODE_BRK || rxData == CODE_EXT) errNext = 1'b1;
          else                                          doBreak = 1'b1;
        end
        ST_EXT: begin
          stateNext = ST_IDLE;
          if (rxData == CODE_BRK)      stateNext = ST_EXT_BRK;
          else if (rxData == CODE_EXT) errNext   = 1'b1;
          else                         doMake    = EXT_AS_BASE;
        end
        default: begin
          stateNext = ST_IDLE;
          if (rxData == CODE_BRK || rxData == CODE_EXT) errNext = 1'b1;
          else                                          doBreak = EXT_AS_BASE;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (toCnt == TO_LAST) begin
        stateNext = ST_IDLE;
        toCntNext = '0;
        errNext   = 1'b1;
      end else begin
        toCntNext = toCnt + 1'b1;
      end
    end
  end

  // Key state update and event request; unmapped or out-of-range keys are inert.
  always_comb begin
    mapped      = mapCode(rxData);
    keyIdx      = mapped[4:0];
    keyHit      = mapped[5] && (32'(keyIdx) < NUM_KEYS);
    keyOneHot   = KEY_ONE << keyIdx;
    keyHeld     = |(keyState & keyOneHot);
    keyNext     = keyState;
    pushReq     = 1'b0;
    pushPressed = 1'b0;
    if (doClear) begin
      keyNext = '0;
    end else if (doMake && keyHit) begin
      pushPressed = 1'b1;
      if (!keyHeld) begin
        keyNext = keyState | keyOneHot;
        pushReq = 1'b1;
      end else begin
        pushReq = REPEAT_EVENTS;
      end
    end else if (doBreak && keyHit && keyHeld) begin
      keyNext = keyState & ~keyOneHot;
      pushReq = 1'b1;
    end
  end

  // FIFO control; head outputs are registered copies of the next head entry.
  always_comb begin
    pop       = bus.evValid && bus.evReady;
    full      = (count == DEPTH_CNT);
    pushOk    = pushReq && (!full || pop);
    drop      = pushReq && full && !pop;
    pushEntry = {pushPressed, keyIdx};
    rdNext    = rdPtr + 1'b1;
    countNext = count;
    if (pushOk && !pop)      countNext = count + 1'b1;
    else if (!pushOk && pop) countNext = count - 1'b1;
    validNext = (countNext != '0);
    headNext  = {bus.evPressed, bus.evKey};
    if (pop) begin
      if (count > CNT_W'(1)) headNext = fifoMem[rdNext];
      else if (pushOk)       headNext = pushEntry;
    end else if (count == '0 && pushOk) begin
      headNext = pushEntry;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      toCnt         <= '0;
      syncError     <= 1'b0;
      keyState      <= '0;
      evOverflow    <= 1'b0;
      rdPtr         <= '0;
      wrPtr         <= '0;
      count         <= '0;
      bus.evValid   <= 1'b0;
      bus.evKey     <= 5'd0;
      bus.evPressed <= 1'b0;
    end else begin
      state         <= stateNext;
      toCnt         <= toCntNext;
      syncError     <= errNext;
      keyState      <= keyNext;
      count         <= countNext;
      bus.evValid   <= validNext;
      bus.evKey     <= headNext[4:0];
      bus.evPressed <= headNext[5];
      if (pop)    rdPtr <= rdNext;
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)               evOverflow <= 1'b1;
      else if (clearOverflow) evOverflow <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (pushOk) fifoMem[wrPtr] <= pushEntry;
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: two instances fed the same byte stream,
// A = 29 keys/depth 4/no ext/no repeat, B = 32 keys/depth 8/ext as base/repeat.
module tb_ps2_key_tracker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        clrOv;
  logic [28:0] ksA;
  logic [31:0] ksB;
  logic        ovA, ovB, seA, seB;
  int          checks   = 0;
  int          failures = 0;

  ps2_key_tracker_if ifA ();
  ps2_key_tracker_if ifB ();

  ps2_key_tracker #(.NUM_KEYS(29), .FIFO_DEPTH(4), .EXT_AS_BASE(1'b0),
                    .REPEAT_EVENTS(1'b0), .TIMEOUT_CYCLES(100)) dutA (
    .CLOCK_50(clk), .resetn(resetn), .bus(ifA), .keyState(ksA),
    .evOverflow(ovA), .clearOverflow(clrOv), .syncError(seA));

  ps2_key_tracker #(.NUM_KEYS(32), .FIFO_DEPTH(8), .EXT_AS_BASE(1'b1),
                    .REPEAT_EVENTS(1'b1), .TIMEOUT_CYCLES(100)) dutB (
    .CLOCK_50(clk), .resetn(resetn), .bus(ifB), .keyState(ksB),
    .evOverflow(ovB), .clearOverflow(clrOv), .syncError(seB));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkEv(input string tag, input logic v, input logic [4:0] k, input logic p,
                       input bit expV, input int expK, input bit expP);
    chk({tag, ".valid"}, 32'(v), 32'(expV));
    if (expV) begin
      chk({tag, ".key"}, 32'(k), 32'(expK));
      chk({tag, ".pressed"}, 32'(p), 32'(expP));
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    ifA.rxData = b; ifA.rxValid = 1'b1;
    ifB.rxData = b; ifB.rxValid = 1'b1;
    tick();
    ifA.rxValid = 1'b0; ifB.rxValid = 1'b0;
  endtask

  task automatic setReady(input logic r);
    ifA.evReady = r;
    ifB.evReady = r;
  endtask

  task automatic pop();
    setReady(1'b1);
    tick();
    setReady(1'b0);
  endtask

  initial begin
    int pulsesA, pulsesB, at;
    resetn = 1'b0; clrOv = 1'b0;
    ifA.rxData = 8'h00; ifA.rxValid = 1'b0;
    ifB.rxData = 8'h00; ifB.rxValid = 1'b0;
    setReady(1'b0);
    tick(); tick();
    chk("rst.ksA", 32'(ksA), 32'h0);
    chkEv("rst.A", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b0, 0, 1'b0);
    chk("rst.evKeyA", 32'(ifA.evKey), 32'h0);
    chk("rst.evPressedA", 32'(ifA.evPressed), 32'h0);
    chk("rst.ovA", 32'(ovA), 32'h0);
    chk("rst.seA", 32'(seA), 32'h0);
    chk("rst.ksB", ksB, 32'h0);
    resetn = 1'b1;
    tick();

    // Press and release of key 16 with the consumer always ready.
    setReady(1'b1);
    sendByte(8'h1D);
    chk("pr.ksA", 32'(ksA), 32'h0001_0000);
    chk("pr.ksB", ksB, 32'h0001_0000);
    chkEv("pr.evA", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 16, 1'b1);
    chkEv("pr.evB", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 16, 1'b1);
    tick();
    chk("pr.drainA", 32'(ifA.evValid), 32'h0);
    chk("pr.holdKeyA", 32'(ifA.evKey), 32'd16);
    sendByte(8'hF0);
    chk("pr.f0ksA", 32'(ksA), 32'h0001_0000);
    sendByte(8'h1D);
    chk("rl.ksA", 32'(ksA), 32'h0);
    chkEv("rl.evA", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 16, 1'b0);
    chkEv("rl.evB", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 16, 1'b0);
    tick();
    chk("rl.drainB", 32'(ifB.evValid), 32'h0);
    setReady(1'b0);

    // Multi-key with a typematic repeat of key 15.
    sendByte(8'h15); sendByte(8'h24); sendByte(8'h15); sendByte(8'hF0); sendByte(8'h15);
    chk("mk.ksA", 32'(ksA), 32'h0002_0000);
    chk("mk.ksB", ksB, 32'h0002_0000);
    chkEv("mk.A1", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 15, 1'b1);
    chkEv("mk.B1", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 15, 1'b1);
    pop();
    chkEv("mk.A2", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 17, 1'b1);
    chkEv("mk.B2", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 17, 1'b1);
    pop();
    chkEv("mk.A3", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 15, 1'b0);
    chkEv("mk.B3", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 15, 1'b1);
    pop();
    chk("mk.A4empty", 32'(ifA.evValid), 32'h0);
    chkEv("mk.B4", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 15, 1'b0);
    pop();
    chk("mk.B5empty", 32'(ifB.evValid), 32'h0);
    sendByte(8'hF0); sendByte(8'h24);
    chkEv("mk.relA", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 17, 1'b0);
    chkEv("mk.relB", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 17, 1'b0);
    pop();

    // Extended Enter: discarded by A, decoded as base code by B.
    sendByte(8'hE0); sendByte(8'h5A);
    chk("ext.mkKsA", 32'(ksA), 32'h0);
    chk("ext.mkValidA", 32'(ifA.evValid), 32'h0);
    chk("ext.mkKsB", ksB, 32'h2000_0000);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h5A);
    chk("ext.brKsA", 32'(ksA), 32'h0);
    chk("ext.brValidA", 32'(ifA.evValid), 32'h0);
    chk("ext.brKsB", ksB, 32'h0);
    chkEv("ext.B1", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 29, 1'b1);
    pop();
    chkEv("ext.B2", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 29, 1'b0);
    pop();
    chk("ext.Bempty", 32'(ifB.evValid), 32'h0);

    // Overflow of A's 4-deep FIFO, then pop+push while full, then drop vs clear.
    sendByte(8'h16); sendByte(8'h1E); sendByte(8'h26); sendByte(8'h25);
    chk("ov.notYetA", 32'(ovA), 32'h0);
    sendByte(8'h2E);
    chk("ov.flagA", 32'(ovA), 32'h1);
    chk("ov.flagB", 32'(ovB), 32'h0);
    chk("ov.ksA", 32'(ksA), 32'h0000_003E);
    chkEv("ov.headA", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 1, 1'b1);
    ifA.rxData = 8'h36; ifA.rxValid = 1'b1;
    ifB.rxData = 8'h36; ifB.rxValid = 1'b1;
    setReady(1'b1);
    tick();
    ifA.rxValid = 1'b0; ifB.rxValid = 1'b0;
    setReady(1'b0);
    chk("pp.ksA", 32'(ksA), 32'h0000_007E);
    chk("pp.flagA", 32'(ovA), 32'h1);
    chkEv("pp.headA", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 2, 1'b1);
    ifA.rxData = 8'h3D; ifA.rxValid = 1'b1;
    ifB.rxData = 8'h3D; ifB.rxValid = 1'b1;
    clrOv = 1'b1;
    tick();
    ifA.rxValid = 1'b0; ifB.rxValid = 1'b0;
    chk("dc.flagA", 32'(ovA), 32'h1);
    chk("dc.ksA", 32'(ksA), 32'h0000_00FE);
    chk("dc.ksB", ksB, 32'h0000_00FE);
    tick();
    clrOv = 1'b0;
    chk("clr.flagA", 32'(ovA), 32'h0);
    chkEv("dr.A1", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 2, 1'b1);
    chkEv("dr.B1", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 2, 1'b1);
    pop();
    chkEv("dr.A2", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 3, 1'b1);
    chkEv("dr.B2", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 3, 1'b1);
    pop();
    chkEv("dr.A3", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 4, 1'b1);
    chkEv("dr.B3", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 4, 1'b1);
    pop();
    chkEv("dr.A4", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 6, 1'b1);
    chkEv("dr.B4", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 5, 1'b1);
    pop();
    chk("dr.A5empty", 32'(ifA.evValid), 32'h0);
    chkEv("dr.B5", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 6, 1'b1);
    pop();
    chkEv("dr.B6", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 7, 1'b1);
    pop();
    chk("dr.B7empty", 32'(ifB.evValid), 32'h0);

    // Self-test byte clears every held key without events.
    sendByte(8'hAA);
    chk("st.ksA", 32'(ksA), 32'h0);
    chk("st.ksB", ksB, 32'h0);
    chk("st.validA", 32'(ifA.evValid), 32'h0);
    chk("st.validB", 32'(ifB.evValid), 32'h0);

    // Timeout after a lone break prefix.
    sendByte(8'hF0);
    pulsesA = 0; pulsesB = 0; at = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (seA) begin pulsesA++; at = c; end
      if (seB) pulsesB++;
    end
    chk("to.pulsesA", 32'(pulsesA), 32'd1);
    chk("to.pulsesB", 32'(pulsesB), 32'd1);
    chk("to.window", 32'((at >= 99) && (at <= 101)), 32'd1);
    sendByte(8'h29);
    chk("to.makeKsA", 32'(ksA), 32'h1000_0000);
    chkEv("to.makeA", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 28, 1'b1);
    chkEv("to.makeB", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 28, 1'b1);
    pop();
    sendByte(8'hAA);

    // Unexpected prefix inside a break sequence.
    sendByte(8'hF0); sendByte(8'hE0);
    chk("ue.seA", 32'(seA), 32'h1);
    chk("ue.seB", 32'(seB), 32'h1);
    tick();
    chk("ue.seAlow", 32'(seA), 32'h0);
    sendByte(8'h1D);
    chk("ue.ksA", 32'(ksA), 32'h0001_0000);
    chkEv("ue.evA", ifA.evValid, ifA.evKey, ifA.evPressed, 1'b1, 16, 1'b1);
    pop();

    // Enter is beyond A's key range, inside B's.
    sendByte(8'h5A);
    chk("nk.ksA", 32'(ksA), 32'h0001_0000);
    chk("nk.validA", 32'(ifA.evValid), 32'h0);
    chk("nk.ksB", ksB, 32'h2001_0000);
    chkEv("nk.evB", ifB.evValid, ifB.evKey, ifB.evPressed, 1'b1, 29, 1'b1);
    pop();

    // Asynchronous reset between E0 and F0.
    sendByte(8'h1E);
    sendByte(8'hE0);
    #1 resetn = 1'b0;
    #1;
    chk("ar.ksA", 32'(ksA), 32'h0);
    chk("ar.validA", 32'(ifA.evValid), 32'h0);
    chk("ar.keyA", 32'(ifA.evKey), 32'h0);
    chk("ar.pressedA", 32'(ifA.evPressed), 32'h0);
    chk("ar.ksB", ksB, 32'h0);
    chk("ar.validB", 32'(ifB.evValid), 32'h0);
    tick();
    resetn = 1'b1;
    tick();
    sendByte(8'hF0); sendByte(8'h5A);
    chk("ar.postKsA", 32'(ksA), 32'h0);
    chk("ar.postValidA", 32'(ifA.evValid), 32'h0);
    chk("ar.postSeA", 32'(seA), 32'h0);
    chk("ar.postKsB", ksB, 32'h0);
    chk("ar.postValidB", 32'(ifB.evValid), 32'h0);
    chk("ar.postSeB", 32'(seB), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised PS/2 scan-code set 2 decoder sitting between PS2_Controller (received byte + one-cycle strobe) and the game/record logic.
- Tracks held/released state for up to 32 mapped keys with correct per-key break handling.
- Handles the E0 extended prefix, inter-byte timeout and keyboard self-test bytes.
- Queues press/release events in a ready/valid FIFO for the record path.

Parameters:
- NUM_KEYS, 29: keys tracked, 1..32. Map indices >= NUM_KEYS are ignored.
- FIFO_DEPTH, 8: event FIFO entries. Power of 2, >= 2.
- EXT_AS_BASE, 0: 1 = E0-prefixed code is decoded as its base code; 0 = whole E0 sequence discarded.
- REPEAT_EVENTS, 0: 1 = typematic repeat makes of an already-held key push press events; 0 = they are suppressed.
- TIMEOUT_CYCLES, 2500000: cycles (50 ms at 50 MHz) allowed between a prefix byte and the following byte.

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rxData  in  8  byte from PS2_Controller
- rxValid  in  1  one-cycle strobe, rxData valid
- keyState  out  NUM_KEYS  1 = key held
- evValid  out  1  FIFO head valid
- evReady  in  1  consumer accepts head
- evKey  out  5  head key index
- evPressed  out  1  head: 1 = press, 0 = release
- evOverflow  out  1  sticky, an event was dropped
- clearOverflow  in  1  clears evOverflow
- syncError  out  1  one-cycle pulse on timeout or unexpected byte

Behaviour:
- Reset, asynchronous: keyState=0, FIFO empty, evValid=0, evKey=0, evPressed=0, evOverflow=0, syncError=0, FSM=IDLE, timeout counter=0. Reset mid-sequence abandons the sequence with no event.
- Key map, code->index:
  - 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9
  - 0E->10, 4E->11, 55->12, 66->13, 0D->14, 15->15, 1D->16, 24->17
  - 2D->18, 2C->19, 35->20, 3C->21, 43->22, 44->23, 4D->24, 54->25
  - 5B->26, 5D->27, 29->28, 5A->29 (Enter), 76->30 (Esc), 12->31 (LShift)
  - Unmapped codes: no state change, no event.
- FSM, advancing only on rxValid:
  - IDLE: F0->BREAK; E0->EXT; AA or FC->clear all keyState, no events, stay; FA/EE/FE/00/FF->ignore; other->make(code).
  - BREAK: any code->break(code)->IDLE.
  - EXT: F0->EXT_BREAK; E0 or F0 repeated->syncError, IDLE; other->make if EXT_AS_BASE, else discard->IDLE.
  - EXT_BREAK: code->break if EXT_AS_BASE, else discard->IDLE.
  - BREAK receiving F0 or E0: syncError, IDLE.
- make(k): if keyState[k]=0, set it and push (k,1). If already 1, push only when REPEAT_EVENTS=1.
- break(k): if keyState[k]=1, clear it and push (k,0). If already 0, nothing.
- Timeout: counter runs in BREAK/EXT/EXT_BREAK, clears on every rxValid. On reaching TIMEOUT_CYCLES-1: ->IDLE, syncError pulse.
- Latency: byte strobed in cycle N -> keyState and FIFO write at edge ending N. evValid high in N+1 if the FIFO was empty. No fall-through.
- FIFO:
  - Pop when evValid&&evReady. evKey/evPressed reflect the head.
  - Push while full without a same-cycle pop: event dropped, evOverflow=1. keyState is still updated.
  - Push while full with a same-cycle pop: push accepted.
  - Empty: evValid=0 and evKey/evPressed hold their last value.
- Overflow flag: clearOverflow clears it. A drop in the same cycle wins, flag stays 1.
- Count widths: FIFO pointers are log2(FIFO_DEPTH) and wrap; the count is one bit wider.

Test Plan:
- Press/release: reset, bytes 1D, F0 1D, evReady=1 -> keyState[16] goes 1 then 0; events (16,1) then (16,0); no other bits change.
- Multi-key and repeat: 15, 24, 15, F0 15 with REPEAT_EVENTS=0 -> keyState[15] and [17] set, then [15] clears with [17] still held; exactly 3 events. With REPEAT_EVENTS=1 -> 4 events.
- Extended: E0 5A, E0 F0 5A -> with EXT_AS_BASE=0, keyState=0 and no events; with EXT_AS_BASE=1, events (29,1) and (29,0).
- Overflow: FIFO_DEPTH=4, evReady=0, make 16,1E,26,25,2E -> 4 entries held, evOverflow=1, keyState[1..5]=1. Then pop and push in the same cycle while full -> entry accepted. clearOverflow -> flag 0.
- Timeout/self-test: F0, then 2500000 idle cycles -> one syncError pulse, FSM IDLE; a later 29 is a make. Then AA -> keyState=0, no events.
- Async reset: assert resetn=0 between E0 and F0 -> all outputs 0. The next bytes F0 5A after release are decoded as a break of an unheld key, producing no event.
